// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, captures instruction_memory
// output into an IF/ID register with a valid/ready handshake toward decode,
// and handles branch/jump redirect with flush plus a sticky illegal-target fault.
module fetch_unit #(
  parameter int unsigned IMEM_BYTES = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instr_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  // IMEM_BYTES is a power of two, so the wrap is a simple mask.
  localparam logic [31:0] PC_MASK   = 32'(IMEM_BYTES - 1);
  localparam logic [31:0] IMEM_SIZE = 32'(IMEM_BYTES);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] out_instr_nxt;
  logic [31:0] out_pc_nxt;
  logic        out_valid_nxt;
  logic        fault_nxt;

  logic        can_load;
  logic        redirect_bad;
  logic [31:0] next_pc;

  assign can_load     = !out_valid || out_ready;
  assign next_pc      = (pc + 32'd4) & PC_MASK;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= IMEM_SIZE);

  // State and output registers; reset returns everything to its boot values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_pc    <= 32'd0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      out_valid <= out_valid_nxt;
      out_instr <= out_instr_nxt;
      out_pc    <= out_pc_nxt;
      fault     <= fault_nxt;
    end
  end

  // Next-state and datapath selection; default is a full hold (stall).
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    out_valid_nxt = out_valid;
    out_instr_nxt = out_instr;
    out_pc_nxt    = out_pc;
    fault_nxt     = fault;

    case (state)
      // One idle cycle so instruction_memory sees a stable pc; redirects ignored.
      BOOT: begin
        state_nxt = RUN;
      end

      RUN: begin
        if (redirect_valid && redirect_bad) begin
          // Illegal target: drop the output, freeze pc, go terminal.
          out_valid_nxt = 1'b0;
          fault_nxt     = 1'b1;
          state_nxt     = FAULT;
        end else if (redirect_valid) begin
          // Legal target: flush the output register; a transfer offered this
          // cycle has already been consumed by decode, so nothing is lost.
          pc_nxt        = redirect_pc;
          out_valid_nxt = 1'b0;
        end else if (can_load) begin
          out_instr_nxt = instr_in;
          out_pc_nxt    = pc;
          out_valid_nxt = 1'b1;
          pc_nxt        = next_pc;
        end
      end

      // Terminal until reset: nothing moves.
      FAULT: begin
        out_valid_nxt = 1'b0;
        fault_nxt     = 1'b1;
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

endmodule
